octal_key_onehot_scanner: RTL and testbench
===========================================

Name: octal_key_onehot_scanner

Overview:
- Upstream front end for the octal-to-binary encoder stage: conditions 8 raw key/switch lines and delivers a clean one-hot 8-bit code, one per key press.
- Per line: 2-flop synchroniser, then counter debounce.
- A 3-state controller emits exactly one one-hot word per press, holds it under a valid/ready handshake, and rejects simultaneous multi-key presses.
- The output drives the downstream encoder's 8-bit input directly. That encoder only decodes legal one-hot codes, so this block must never present a multi-hot word while out_valid=1.

Parameters:
- NUM_KEYS, 8, number of input lines; fixed at 8 for this stage, parameterised for reuse.
- DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised line must differ from its stable value before the stable value flips; legal range >= 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES), debounce counter width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; one clock; reset is synchronous and active-high.
- key_raw  input  NUM_KEYS  asynchronous raw key lines, 1 = pressed.
- out_ready  input  1  consumer accepts onehot_out when high with out_valid.
- onehot_out  output  NUM_KEYS  latched one-hot key code; 0 when out_valid=0.
- out_valid  output  1  onehot_out holds a single accepted press.
- err_multi  output  1  one-cycle pulse: more than one line became stable-high in the same IDLE cycle.
- busy  output  1  high in VALID or RELEASE.

Behaviour:
- Reset (rst=1 at a clk edge):
  - sync flops, stable vector, counters, onehot_out, out_valid, err_multi and busy all go to 0.
  - state goes to IDLE.
  - Reset mid-handshake drops out_valid with no acceptance.
- Debounce, per line:
  - s2 is the second sync flop.
  - If s2 == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= s2, cnt <= 0.
  - Else: cnt <= cnt+1.
  - Glitches shorter than DEBOUNCE_CYCLES cycles never change stable. Release is debounced identically.
- Latency: counting the first edge that samples key_raw high as edge 1, stable rises at edge DEBOUNCE_CYCLES+2 and out_valid rises at edge DEBOUNCE_CYCLES+3 (edge 7 for default).
- FSM, all outputs registered:
  - IDLE:
    - stable == 0: stay.
    - popcount(stable) == 1: onehot_out <= stable, out_valid <= 1, go VALID.
    - popcount(stable) > 1: err_multi <= 1 for one cycle, go RELEASE; onehot_out stays 0.
  - VALID:
    - out_valid=1 and onehot_out frozen.
    - out_ready=1: out_valid <= 0, onehot_out <= 0, go RELEASE.
    - Other keys becoming stable here are ignored and produce no error.
  - RELEASE: wait until stable == 0 (all keys debounced released), then go IDLE.
- Ordering and repeats:
  - Keys stabilising on different cycles: the first one wins. Later keys are absorbed because RELEASE requires all lines released.
  - A held key never repeats.
- Handshake:
  - out_ready is ignored outside VALID.
  - out_valid never deasserts without out_ready, except on rst.
  - A transfer occurs on any edge with out_valid & out_ready; out_ready may be tied high.
- err_multi is high exactly one cycle per multi-press event, on the cycle after detection.
- Invariant: out_valid=1 implies $onehot(onehot_out), checked by assertion.

Decomposition:
- Shared package octal_key_pkg:
  - state typedef {IDLE, VALID, RELEASE}.
  - NUM_KEYS_DEF = 8.
  - DEBOUNCE_CYCLES_DEF = 4.
- Sub-module key_debounce: 1-bit line, parameter DEBOUNCE_CYCLES, ports clk/rst/raw/stable. It contains the 2-flop sync and counter and is instantiated NUM_KEYS times in a generate loop.
- The top level holds the popcount check, the FSM and the output registers.

Test Plan:
- Reset with key_raw=8'h00 → all outputs 0. Then raise key_raw=8'h04 and hold → out_valid rises on edge 7 with onehot_out=8'h04; with out_ready=1, out_valid drops the next cycle.
- key_raw[5] pulses high for 3 cycles (< DEBOUNCE_CYCLES) → no out_valid and no err_multi at any time.
- key_raw=8'h11 set on the same edge → err_multi pulses exactly 1 cycle and out_valid stays 0. Release both, then press 8'h80 → onehot_out=8'h80.
- out_ready=0 while key 8'h02 is valid: hold 20 cycles → out_valid=1 and onehot_out=8'h02 stable throughout. Press key 8'h08 meanwhile → no change. Raise out_ready → single transfer.
- Hold key 8'h01 for 50 cycles with out_ready=1 → exactly one transfer. Release, wait 6 cycles, repress → second transfer.
- Assert rst in VALID with onehot_out=8'h40 → next edge: out_valid=0, onehot_out=0, busy=0. Deassert rst with key still held → a new press is reported after the debounce latency.

Source files
------------

// File: rtl/octal_key_onehot_scanner_pkg.sv
// Shared types and default sizing for the octal key scanner front end.
package octal_key_pkg;

    // Controller states: waiting for a press, presenting a code, waiting for release.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        VALID   = 2'd1,
        RELEASE = 2'd2
    } state_e;

    localparam int NUM_KEYS_DEF        = 8;
    localparam int DEBOUNCE_CYCLES_DEF = 4;

endpackage

// File: rtl/octal_key_onehot_scanner_debounce.sv
// Single-line conditioner: two-flop synchroniser followed by a counter debounce.
// The stable output only flips after the synchronised line has disagreed with it
// for DEBOUNCE_CYCLES consecutive cycles; presses and releases are treated alike.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q;
    logic             s2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Synchroniser chain for the asynchronous raw line.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= raw;
            s2_q <= s1_q;
        end
    end

    // Debounce decision: count consecutive disagreements, flip on the last one.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (s2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = s2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/octal_key_onehot_scanner.sv
// Key scanner top: debounces every line, then a three-state controller turns each
// single-key press into one one-hot word held under a valid/ready handshake.
// Simultaneous multi-key presses are flagged on err_multi and never presented.
module octal_key_onehot_scanner
    import octal_key_pkg::*;
#(
    parameter int NUM_KEYS        = NUM_KEYS_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_raw,
    input  logic                out_ready,
    output logic [NUM_KEYS-1:0] onehot_out,
    output logic                out_valid,
    output logic                err_multi,
    output logic                busy
);

    logic [NUM_KEYS-1:0] stable_vec;
    logic                any_stable;
    logic                single_stable;

    state_e              state_q;
    state_e              state_d;
    logic [NUM_KEYS-1:0] onehot_q;
    logic [NUM_KEYS-1:0] onehot_d;
    logic                valid_q;
    logic                valid_d;
    logic                err_q;
    logic                err_d;
    logic                busy_q;
    logic                busy_d;

    // One conditioner per key line.
    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_line
            key_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_debounce (
                .clk    (clk),
                .rst    (rst),
                .raw    (key_raw[gi]),
                .stable (stable_vec[gi])
            );
        end
    endgenerate

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    assign any_stable    = (stable_vec != '0);
    assign single_stable = any_stable &&
                           ((stable_vec & (stable_vec - NUM_KEYS'(1))) == '0);

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; RELEASE waits for every line so later keys are absorbed.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (any_stable) begin
                    state_d = single_stable ? VALID : RELEASE;
                end
            end
            VALID: begin
                if (out_ready) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!any_stable) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output next values; the word is captured once in IDLE and frozen in VALID.
    always_comb begin
        onehot_d = onehot_q;
        valid_d  = valid_q;
        err_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (single_stable) begin
                    onehot_d = stable_vec;
                    valid_d  = 1'b1;
                end else if (any_stable) begin
                    err_d = 1'b1;
                end
            end
            VALID: begin
                if (out_ready) begin
                    onehot_d = '0;
                    valid_d  = 1'b0;
                end
            end
            default: begin
                onehot_d = '0;
                valid_d  = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Registered outputs so the downstream encoder sees glitch-free values.
    always_ff @(posedge clk) begin
        if (rst) begin
            onehot_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            onehot_q <= onehot_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign onehot_out = onehot_q;
    assign out_valid  = valid_q;
    assign err_multi  = err_q;
    assign busy       = busy_q;

    // The downstream encoder only decodes legal codes.
    a_valid_onehot : assert property (@(posedge clk) disable iff (rst)
        valid_q |-> $onehot(onehot_q));

endmodule

// File: tb/tb_octal_key_onehot_scanner.sv
// Directed bench for the octal key scanner: latency, glitch rejection,
// multi-press error, back-pressure, hold without repeat, and mid-handshake reset.
module tb_octal_key_onehot_scanner;

    logic       clk;
    logic       rst;
    logic [7:0] key_raw;
    logic       out_ready;
    logic [7:0] onehot_out;
    logic       out_valid;
    logic       err_multi;
    logic       busy;

    int compared   = 0;
    int mismatched = 0;
    int transfers;

    octal_key_onehot_scanner dut (
        .clk        (clk),
        .rst        (rst),
        .key_raw    (key_raw),
        .out_ready  (out_ready),
        .onehot_out (onehot_out),
        .out_valid  (out_valid),
        .err_multi  (err_multi),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-22s observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        rst       = 1'b1;
        key_raw   = 8'h00;
        out_ready = 1'b1;
        ticks(2);
        rst = 1'b0;
        check("rst_onehot", onehot_out, 8'h00);
        check("rst_valid",  {7'd0, out_valid}, 8'd0);
        check("rst_err",    {7'd0, err_multi}, 8'd0);
        check("rst_busy",   {7'd0, busy},      8'd0);

        // Single press: out_valid rises on edge 7, transfers on edge 8.
        key_raw = 8'h04;
        ticks(6);
        check("p04_edge6_valid", {7'd0, out_valid}, 8'd0);
        tick();
        check("p04_edge7_valid",  {7'd0, out_valid}, 8'd1);
        check("p04_edge7_onehot", onehot_out, 8'h04);
        check("p04_edge7_busy",   {7'd0, busy}, 8'd1);
        tick();
        check("p04_xfer_valid",  {7'd0, out_valid}, 8'd0);
        check("p04_xfer_onehot", onehot_out, 8'h00);
        check("p04_release_busy", {7'd0, busy}, 8'd1);
        key_raw = 8'h00;
        ticks(10);
        check("p04_idle_busy", {7'd0, busy}, 8'd0);

        // Short glitch on key 5 must never register.
        key_raw = 8'h20;
        tick();
        check("glitch_valid", {7'd0, out_valid}, 8'd0);
        ticks(2);
        key_raw = 8'h00;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("glitch_valid", {7'd0, out_valid}, 8'd0);
            check("glitch_err",   {7'd0, err_multi}, 8'd0);
        end
        check("glitch_busy", {7'd0, busy}, 8'd0);

        // Two keys on the same edge: one-cycle error, no code.
        key_raw = 8'h11;
        ticks(6);
        check("multi_edge6_err", {7'd0, err_multi}, 8'd0);
        tick();
        check("multi_edge7_err",   {7'd0, err_multi}, 8'd1);
        check("multi_edge7_valid", {7'd0, out_valid}, 8'd0);
        check("multi_edge7_onehot", onehot_out, 8'h00);
        tick();
        check("multi_edge8_err",   {7'd0, err_multi}, 8'd0);
        check("multi_edge8_valid", {7'd0, out_valid}, 8'd0);
        key_raw = 8'h00;
        ticks(10);
        check("multi_idle_busy", {7'd0, busy}, 8'd0);
        key_raw = 8'h80;
        ticks(7);
        check("p80_valid",  {7'd0, out_valid}, 8'd1);
        check("p80_onehot", onehot_out, 8'h80);
        key_raw = 8'h00;
        ticks(10);

        // Back-pressure: code held frozen, extra key ignored, one transfer.
        out_ready = 1'b0;
        key_raw   = 8'h02;
        ticks(7);
        check("bp_valid",  {7'd0, out_valid}, 8'd1);
        check("bp_onehot", onehot_out, 8'h02);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) key_raw = 8'h0A;
            tick();
            check("bp_hold_valid",  {7'd0, out_valid}, 8'd1);
            check("bp_hold_onehot", onehot_out, 8'h02);
            check("bp_hold_err",    {7'd0, err_multi}, 8'd0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_xfer_valid", {7'd0, out_valid}, 8'd0);
        tick();
        check("bp_after_valid", {7'd0, out_valid}, 8'd0);
        key_raw = 8'h00;
        ticks(10);
        check("bp_idle_busy", {7'd0, busy}, 8'd0);

        // Long hold produces exactly one transfer; a repress gives another.
        key_raw   = 8'h01;
        transfers = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (out_valid && out_ready) transfers++;
        end
        check("hold_transfers", 8'(transfers), 8'd1);
        key_raw = 8'h00;
        ticks(6);
        key_raw   = 8'h01;
        transfers = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid && out_ready) begin
                transfers++;
                check("repress_onehot", onehot_out, 8'h01);
            end
        end
        check("repress_transfers", 8'(transfers), 8'd1);
        key_raw = 8'h00;
        ticks(10);

        // Reset while presenting a code, then recovery with the key still held.
        out_ready = 1'b0;
        key_raw   = 8'h40;
        ticks(7);
        check("r40_valid",  {7'd0, out_valid}, 8'd1);
        check("r40_onehot", onehot_out, 8'h40);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("r40_rst_valid",  {7'd0, out_valid}, 8'd0);
        check("r40_rst_onehot", onehot_out, 8'h00);
        check("r40_rst_busy",   {7'd0, busy}, 8'd0);
        ticks(6);
        check("r40_edge6_valid", {7'd0, out_valid}, 8'd0);
        tick();
        check("r40_edge7_valid",  {7'd0, out_valid}, 8'd1);
        check("r40_edge7_onehot", onehot_out, 8'h40);
        out_ready = 1'b1;
        tick();
        check("r40_xfer_valid", {7'd0, out_valid}, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
